rr_go_arbiter: RTL and testbench
================================

// Module: rr_go_arbiter
// PURPOSE
//  Round-robin arbiter that produces the grant vector checked by the round-robin grant checker.
//  A rotating pointer selects one candidate requester. Grant goes to that requester only if it
//    is requesting; otherwise no grant is given.
//  The pointer advances one slot on each rising edge of go.
//  A lock input lets the current grantee hold the resource. While held, pointer advances are
//    deferred, bounded by a hold timeout.
// PARAMETERS
//  N         8    number of requesters, N >= 2, need not be a power of two
//  PW        $clog2(N)   pointer width (derived, do not override)
//  MAX_HOLD  16   max consecutive locked cycles before a forced advance, >= 2
// PORTS
//  clk       in   1    rising-edge clock, single clock domain
//  reset     in   1    synchronous, active-high reset
//  req       in   N    request vector, bit i = requester i
//  go        in   1    level input; its rising edge requests a pointer advance
//  lock      in   1    current grantee asks to keep the grant
//  grant     out  N    one-hot or zero grant vector
//  ptr       out  PW   current round-robin pointer
//  pending   out  1    an advance is deferred by lock
//  timeout   out  1    1-cycle pulse when MAX_HOLD forces an advance
// BEHAVIOUR
//  Reset (reset=1 at posedge):
//    ptr=0, state=FREE, pending=0, timeout=0, go_q=0, hold_cnt=0.
//    grant is forced to 0 while reset=1.
//  go_rise = go & ~go_q. go_q is registered every cycle.
//    go already high when reset releases counts as a rise on the first cycle.
//  grant is combinational from the registered ptr: grant[i] = req[i] & (ptr==i) & ~reset.
//    Zero-latency w.r.t. req; at most one bit set.
//  advance: ptr <= (ptr==N-1) ? 0 : ptr+1. Wrap is explicit, never via PW overflow.
//  FSM state FREE:
//    - go_rise: advance. This takes priority over entering HELD, and the state stays FREE.
//    - else if lock & req[ptr]: go to HELD, hold_cnt <= 1.
//  FSM state HELD (priority order, evaluated at each posedge):
//    1. release (~lock | ~req[ptr]):
//       - go to FREE, hold_cnt <= 0.
//       - If pending | go_rise: advance and clear pending.
//       - No timeout pulse, even if hold_cnt == MAX_HOLD-1 (release wins).
//    2. hold_cnt == MAX_HOLD-1:
//       - forced advance, timeout <= 1 for one cycle.
//       - pending <= 0, go to FREE, hold_cnt <= 0.
//       - A go_rise in this same cycle is absorbed (single advance).
//    3. otherwise:
//       - hold_cnt <= hold_cnt+1.
//       - If go_rise: pending <= 1. Multiple rises collapse into one pending advance.
//  ptr changes at most once per cycle, by exactly one slot.
//  After a forced advance, the next cycle is FREE. If lock & req[new ptr], it re-enters HELD.
//  req for a non-pointer slot never produces grant; there is no skip-ahead search.
//  Reset mid-HELD: everything returns to reset values next cycle, and pending is discarded.
//  hold_cnt width is $clog2(MAX_HOLD)+1 and never exceeds MAX_HOLD-1.
//  Assertions (bind-friendly, in-file):
//    - $onehot0(grant).
//    - timeout is never high for 2 consecutive cycles.
//    - ptr < N.
//    - ptr stable when there is no go_rise, no pending release and no timeout.
// TESTING
//  1. reset, req=8'hFF, three go pulses (1 high, 2 low)
//     -> ptr 0->1->2->3, grant 01->02->04->08, each change one cycle after the go rise.
//  2. ptr=7, go pulse -> ptr=0 (wrap).
//     With N=5: ptr=4, go -> ptr=0, and ptr never reaches 5..7.
//  3. ptr=3, req=8'h01, go held constant high
//     -> grant=0 throughout, no further advance until go falls then rises.
//  4. ptr=2, req[2]=1, lock=1, go pulse at locked cycle 3 -> pending=1, ptr stays 2.
//     Drop lock at cycle 6 -> ptr=3, pending=0 next cycle.
//  5. lock=1 and req[2]=1 held, MAX_HOLD=16 -> timeout pulses exactly once, 16 cycles after
//     entering HELD, ptr 2->3, grant -> 0 if req[3]=0.
//  6. HELD with pending=1, reset=1 for one cycle -> ptr=0, pending=0, state FREE,
//     grant=0 during reset, grant=req[0] after.

Source files
------------

// File: rtl/rr_go_arbiter.sv
// Single-pointer round-robin arbiter: the pointer advances on each rising edge of go, and a
// locked grantee can defer those advances for a bounded number of cycles.
module rr_go_arbiter #(
  parameter int unsigned N        = 8,
  parameter int unsigned MAX_HOLD = 16,
  localparam int unsigned PW      = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          go,
  input  logic          lock,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] ptr,
  output logic          pending,
  output logic          timeout
);

  localparam int unsigned HW = $clog2(MAX_HOLD) + 1;

  typedef enum logic [0:0] {StFree, StHeld} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          pending_q, pending_d;
  logic          timeout_q, timeout_d;
  logic          go_q;
  logic          go_rise;
  logic          held_release;
  logic          held_expire;
  logic          advance;

  assign go_rise      = go & ~go_q;
  assign held_release = (state_q == StHeld) & (~lock | ~req[ptr_q]);
  assign held_expire  = (state_q == StHeld) & ~held_release &
                        (hold_cnt_q == HW'(MAX_HOLD - 1));

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    pending_d  = pending_q;
    timeout_d  = 1'b0;
    advance    = 1'b0;
    unique case (state_q)
      StFree: begin
        // A go rise wins over taking the lock in the same cycle.
        if (go_rise) begin
          advance = 1'b1;
        end else if (lock && req[ptr_q]) begin
          state_d    = StHeld;
          hold_cnt_d = HW'(1);
        end
      end
      StHeld: begin
        if (held_release) begin
          state_d    = StFree;
          hold_cnt_d = '0;
          if (pending_q || go_rise) begin
            advance   = 1'b1;
            pending_d = 1'b0;
          end
        end else if (held_expire) begin
          // Forced advance absorbs any go rise seen this cycle.
          advance    = 1'b1;
          timeout_d  = 1'b1;
          pending_d  = 1'b0;
          state_d    = StFree;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
          if (go_rise) pending_d = 1'b1;
        end
      end
      default: state_d = StFree;
    endcase

    ptr_d = ptr_q;
    if (advance) ptr_d = (ptr_q == PW'(N - 1)) ? '0 : ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StFree;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      pending_q  <= 1'b0;
      timeout_q  <= 1'b0;
      go_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      pending_q  <= pending_d;
      timeout_q  <= timeout_d;
      go_q       <= go;
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < int'(N); i++) begin
      grant[i] = req[i] & (ptr_q == PW'(i)) & ~reset;
    end
  end

  assign ptr     = ptr_q;
  assign pending = pending_q;
  assign timeout = timeout_q;

`ifndef SYNTHESIS
  a_grant_onehot0 : assert property (@(posedge clk) $onehot0(grant));
  a_timeout_pulse : assert property (@(posedge clk) disable iff (reset)
                                     timeout_q |=> !timeout_q);
  a_ptr_range     : assert property (@(posedge clk) int'(ptr_q) < int'(N));
  a_ptr_stable    : assert property (@(posedge clk) disable iff (reset)
                                     (!go_rise && !(held_release && pending_q) && !held_expire)
                                     |=> $stable(ptr_q));
`endif

endmodule

// File: tb/tb_rr_go_arbiter.sv
// Directed bench for rr_go_arbiter: a vector table for rotation/wrap/level-go, then hand
// sequences for lock, pending, hold timeout and reset behaviour.
module tb_rr_go_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req;
  logic       go;
  logic       lock;
  logic [7:0] grant;
  logic [2:0] ptr;
  logic       pending;
  logic       timeout;

  logic [4:0] grant5;
  logic [2:0] ptr5;
  logic       pending5;
  logic       timeout5;
  logic       lock5 = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rr_go_arbiter #(.N(8), .MAX_HOLD(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .go     (go),
    .lock   (lock),
    .grant  (grant),
    .ptr    (ptr),
    .pending(pending),
    .timeout(timeout)
  );

  // Non-power-of-two instance sharing go/reset, used to check the explicit wrap.
  rr_go_arbiter #(.N(5), .MAX_HOLD(16)) dut5 (
    .clk    (clk),
    .reset  (reset),
    .req    (req[4:0]),
    .go     (go),
    .lock   (lock5),
    .grant  (grant5),
    .ptr    (ptr5),
    .pending(pending5),
    .timeout(timeout5)
  );

  typedef struct {
    logic       r;
    logic [7:0] q;
    logic       g;
    logic       l;
    logic [7:0] exp_grant;
    logic [2:0] exp_ptr;
    logic [2:0] exp_ptr5;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [7:0] q, input logic g, input logic l);
    reset = r;
    req   = q;
    go    = g;
    lock  = l;
    @(posedge clk);
    #1;
  endtask

  task automatic goto_ptr2();
    step(1'b1, 8'h04, 1'b0, 1'b0);
    step(1'b0, 8'h04, 1'b0, 1'b0);
    step(1'b0, 8'h04, 1'b1, 1'b0);
    step(1'b0, 8'h04, 1'b0, 1'b0);
    step(1'b0, 8'h04, 1'b1, 1'b0);
    step(1'b0, 8'h04, 1'b0, 1'b0);
    chk("setup_ptr2", 32'(ptr), 32'd2);
  endtask

  initial begin
    int n_to;
    reset = 1'b1;
    req   = '0;
    go    = 1'b0;
    lock  = 1'b0;

    //                r     req    go    lock  grant  ptr   ptr5
    vecs.push_back('{1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0});
    vecs.push_back('{1'b0, 8'hFF, 1'b0, 1'b0, 8'h01, 3'd0, 3'd0});
    vecs.push_back('{1'b0, 8'hFF, 1'b1, 1'b0, 8'h02, 3'd1, 3'd1});
    vecs.push_back('{1'b0, 8'hFF, 1'b0, 1'b0, 8'h02, 3'd1, 3'd1});
    vecs.push_back('{1'b0, 8'hFF, 1'b0, 1'b0, 8'h02, 3'd1, 3'd1});
    vecs.push_back('{1'b0, 8'hFF, 1'b1, 1'b0, 8'h04, 3'd2, 3'd2});
    vecs.push_back('{1'b0, 8'hFF, 1'b0, 1'b0, 8'h04, 3'd2, 3'd2});
    vecs.push_back('{1'b0, 8'hFF, 1'b0, 1'b0, 8'h04, 3'd2, 3'd2});
    vecs.push_back('{1'b0, 8'hFF, 1'b1, 1'b0, 8'h08, 3'd3, 3'd3});
    // go held high: no further advance; req[3]=0 so no grant
    vecs.push_back('{1'b0, 8'h01, 1'b1, 1'b0, 8'h00, 3'd3, 3'd3});
    vecs.push_back('{1'b0, 8'h01, 1'b1, 1'b0, 8'h00, 3'd3, 3'd3});
    vecs.push_back('{1'b0, 8'h01, 1'b1, 1'b0, 8'h00, 3'd3, 3'd3});
    vecs.push_back('{1'b0, 8'h01, 1'b0, 1'b0, 8'h00, 3'd3, 3'd3});
    vecs.push_back('{1'b0, 8'h01, 1'b1, 1'b0, 8'h00, 3'd4, 3'd4});
    vecs.push_back('{1'b0, 8'hFF, 1'b0, 1'b0, 8'h10, 3'd4, 3'd4});
    vecs.push_back('{1'b0, 8'hFF, 1'b1, 1'b0, 8'h20, 3'd5, 3'd0});
    vecs.push_back('{1'b0, 8'hFF, 1'b0, 1'b0, 8'h20, 3'd5, 3'd0});
    vecs.push_back('{1'b0, 8'hFF, 1'b1, 1'b0, 8'h40, 3'd6, 3'd1});
    vecs.push_back('{1'b0, 8'hFF, 1'b0, 1'b0, 8'h40, 3'd6, 3'd1});
    vecs.push_back('{1'b0, 8'hFF, 1'b1, 1'b0, 8'h80, 3'd7, 3'd2});
    vecs.push_back('{1'b0, 8'hFF, 1'b0, 1'b0, 8'h80, 3'd7, 3'd2});
    vecs.push_back('{1'b0, 8'hFF, 1'b1, 1'b0, 8'h01, 3'd0, 3'd3});
    vecs.push_back('{1'b0, 8'hFF, 1'b0, 1'b0, 8'h01, 3'd0, 3'd3});
    vecs.push_back('{1'b0, 8'hFF, 1'b1, 1'b0, 8'h02, 3'd1, 3'd4});
    vecs.push_back('{1'b0, 8'hFF, 1'b0, 1'b0, 8'h02, 3'd1, 3'd4});
    vecs.push_back('{1'b0, 8'hFF, 1'b1, 1'b0, 8'h04, 3'd2, 3'd0});

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].q, vecs[i].g, vecs[i].l);
      chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].exp_grant));
      chk($sformatf("vec%0d_ptr", i), 32'(ptr), 32'(vecs[i].exp_ptr));
      chk($sformatf("vec%0d_ptr5", i), 32'(ptr5), 32'(vecs[i].exp_ptr5));
      chk($sformatf("vec%0d_pending", i), 32'(pending), 32'd0);
      chk($sformatf("vec%0d_timeout", i), 32'(timeout), 32'd0);
    end

    // Deferred advance under lock, released by dropping lock.
    goto_ptr2();
    step(1'b0, 8'h0C, 1'b0, 1'b1);
    chk("lk_c1_grant", 32'(grant), 32'h04);
    chk("lk_c1_pending", 32'(pending), 32'd0);
    step(1'b0, 8'h0C, 1'b0, 1'b1);
    step(1'b0, 8'h0C, 1'b1, 1'b1);
    chk("lk_c3_pending", 32'(pending), 32'd1);
    chk("lk_c3_ptr", 32'(ptr), 32'd2);
    step(1'b0, 8'h0C, 1'b0, 1'b1);
    step(1'b0, 8'h0C, 1'b1, 1'b1);
    chk("lk_c5_pending", 32'(pending), 32'd1);
    chk("lk_c5_ptr", 32'(ptr), 32'd2);
    step(1'b0, 8'h0C, 1'b0, 1'b0);
    chk("lk_c6_ptr", 32'(ptr), 32'd3);
    chk("lk_c6_pending", 32'(pending), 32'd0);
    chk("lk_c6_grant", 32'(grant), 32'h08);
    chk("lk_c6_timeout", 32'(timeout), 32'd0);

    // Hold timeout: lock held on req[2] with req[3]=0.
    goto_ptr2();
    n_to = 0;
    for (int c = 1; c <= 20; c++) begin
      step(1'b0, 8'h04, 1'b0, 1'b1);
      if (timeout) n_to++;
      chk($sformatf("to_c%0d_timeout", c), 32'(timeout), (c == 16) ? 32'd1 : 32'd0);
      chk($sformatf("to_c%0d_ptr", c), 32'(ptr), (c < 16) ? 32'd2 : 32'd3);
      chk($sformatf("to_c%0d_grant", c), 32'(grant), (c < 16) ? 32'h04 : 32'h00);
    end
    chk("to_pulse_count", 32'(n_to), 32'd1);

    // Reset while HELD with a pending advance.
    goto_ptr2();
    step(1'b0, 8'h05, 1'b0, 1'b1);
    step(1'b0, 8'h05, 1'b1, 1'b1);
    chk("rst_pre_pending", 32'(pending), 32'd1);
    step(1'b1, 8'h05, 1'b0, 1'b1);
    chk("rst_ptr", 32'(ptr), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_grant", 32'(grant), 32'h00);
    step(1'b0, 8'h05, 1'b0, 1'b0);
    chk("rst_after_grant", 32'(grant), 32'h01);
    chk("rst_after_ptr", 32'(ptr), 32'd0);
    chk("rst_after_pending", 32'(pending), 32'd0);

    // go already high across reset release counts as a rise.
    step(1'b1, 8'h05, 1'b1, 1'b0);
    chk("gorst_ptr", 32'(ptr), 32'd0);
    step(1'b0, 8'h05, 1'b1, 1'b0);
    chk("gorst_after_ptr", 32'(ptr), 32'd1);
    chk("gorst_after_grant", 32'(grant), 32'h00);
    step(1'b0, 8'h05, 1'b1, 1'b0);
    chk("gorst_level_ptr", 32'(ptr), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
